// File: rtl/mips32_pkg.sv
// Shared MIPS32 datapath constants: operand width, multiply iteration count
// and the multiply sequencer state encodings.
package mips32_pkg;

   localparam int unsigned WIDTH      = 32;
   localparam int unsigned ITER_COUNT = 32;
   localparam int unsigned CNT_W      = 5;
   localparam int unsigned STATE_W    = 2;

   localparam logic [STATE_W-1:0] IDLE = 2'd0;
   localparam logic [STATE_W-1:0] RUN  = 2'd1;
   localparam logic [STATE_W-1:0] DONE = 2'd2;

endpackage

// File: rtl/_32bit_adder.sv
// Shared 32-bit ripple/carry adder used by the integer datapath.
module _32bit_adder (
   output logic [31:0] sum,
   output logic        c_out,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        c_in
);

   assign {c_out, sum} = 33'(a) + 33'(b) + 33'(c_in);

endmodule

// File: rtl/mult_sequencer.sv
// Unsigned 32x32->64 shift-add multiplier time-sharing one 32-bit adder.
// Optional MULT_EARLY_TERM_EN: a zero operand skips the iterations (latency 2).
module mult_sequencer
   import mips32_pkg::*;
#(
   parameter int unsigned WIDTH = mips32_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_next;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   add_b;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;
   logic               early_c;

`ifdef MULT_EARLY_TERM_EN
   logic zero_op;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_op <= 1'b0;
      end else if (state == IDLE && start) begin
         zero_op <= (multiplicand == '0) || (multiplier == '0);
      end
   end

   assign early_c = zero_op;
`else
   assign early_c = 1'b0;
`endif

   assign add_b = lo[0] ? mcand : '0;

   _32bit_adder u_adder (
      .sum   (add_sum),
      .c_out (add_cout),
      .a     (hi),
      .b     (add_b),
      .c_in  (1'b0)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN:  if (early_c || count == LAST_ITER) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status flags registered from the next state so they align with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_next != IDLE);
         done <= (state_next == DONE);
      end
   end

   // Product register, multiplicand holding register and iteration counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  hi    <= '0;
                  lo    <= multiplier;
                  mcand <= multiplicand;
                  count <= '0;
               end
            end
            RUN: begin
               if (early_c) begin
                  hi <= '0;
                  lo <= '0;
               end else begin
                  {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
                  // Counter parks at the last iteration instead of wrapping
                  if (count != LAST_ITER) begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
